pf_vf_mux_tx_arb: RTL and testbench
===================================

Name: pf_vf_mux_tx_arb

Overview:
- Packet-aware round-robin arbiter that shares the single host-facing TX path of the PF/VF MUX among NUM_PORTS function-side ports. Port indices match the routing-table pfvf_port numbering.
- Grants at packet granularity: once a multi-beat packet starts on a port, the grant stays on that port until its EOP beat transfers.
- Sits between the per-port TX FIFOs and the shared upstream pipeline stage.

Parameters:
- NUM_PORTS, 4: number of requesting MUX ports; legal range 2..16.
- PORT_W, $clog2(NUM_PORTS): width of port index outputs; derived, not overridden.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  NUM_PORTS  per-port head beat valid.
- in_sop  in  NUM_PORTS  per-port head beat is start of packet.
- in_eop  in  NUM_PORTS  per-port head beat is end of packet.
- out_ready  in  1  shared TX stage accepts a beat this cycle.
- grant  out  NUM_PORTS  one-hot; the port that may transfer this cycle (in_ready per port).
- grant_idx  out  PORT_W  binary index of grant.
- out_valid  out  1  a granted beat is valid this cycle, equal to |(grant & in_valid).
- locked  out  1  arbiter is mid-packet (registered).
- err_proto  out  1  sticky protocol error flag.

Behaviour:
- Transfer on port i: grant[i] & in_valid[i] & out_ready.
- grant, grant_idx and out_valid are combinational from registered state and in_valid. Zero-cycle grant latency; no bubble between back-to-back packets.
- State: lock_r (1b), lock_idx_r (PORT_W), last_idx_r (PORT_W), err_r (1b).
- IDLE (lock_r=0):
  - Pick the first port with in_valid set, scanning last_idx_r+1, +2, ... modulo NUM_PORTS.
  - Only beats with in_sop=1 are eligible.
  - A valid head beat with in_sop=0 in IDLE is not granted, and it sets err_proto.
- IDLE transfer with sop=1, eop=0: lock_r<=1, lock_idx_r<=i, last_idx_r<=i.
- IDLE transfer with sop=1, eop=1 (single-beat packet): last_idx_r<=i, lock_r stays 0.
- LOCKED (lock_r=1):
  - grant=onehot(lock_idx_r) regardless of in_valid. out_valid=in_valid[lock_idx_r]. Other ports are starved.
  - Transfer with eop=1: lock_r<=0. The next cycle is IDLE and arbitration resumes from lock_idx_r+1.
  - Transfer with sop=1 on the locked port: err_proto set; beat still transfers; lock held.
- No valid eligible requester: grant=0, grant_idx=0, out_valid=0.
- out_ready=0: no state update; grant may change in IDLE if in_valid changes. Grant is stable while locked.
- Wrap-around: the scan index wraps modulo NUM_PORTS. For non-power-of-2 NUM_PORTS, indices >= NUM_PORTS are never produced.
- Reset values: lock_r=0, lock_idx_r=0, last_idx_r=NUM_PORTS-1 (port 0 has first priority), err_r=0.
  - Outputs in reset: grant=0, grant_idx=0, out_valid=0, locked=0, err_proto=0.
  - Reset asserted mid-packet drops the lock immediately. Upstream FIFOs are reset in the same domain.
- err_proto is cleared only by rst_n.

Decomposition:
- Add to pf_vf_mux_pkg:
  - localparam MAX_MUX_PORTS=16.
  - typedef t_arb_state enum {ARB_IDLE, ARB_LOCKED}.
  - function onehot_to_idx.
- One sub-module, pf_vf_mux_rr_pick (combinational):
  - Inputs: request vector, last index.
  - Outputs: one-hot pick, index, any.
  - Implemented as a double-width rotate plus priority encode.

Test Plan:
- Out of reset, ports 0..3 all valid single-beat (sop=eop=1), out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; locked stays 0.
- Port 1 sends a 3-beat packet while port 2 is valid -> grant_idx=1 for 3 cycles, locked=1 on beats 2-3; grant_idx=2 on cycle 4.
- Locked on port 3 (NUM_PORTS=4), in_valid[3] drops for 2 cycles -> grant stays 4'b1000, out_valid=0; other ports are not granted; after EOP the next grant is port 0 (wrap).
- out_ready=0 for 5 cycles mid-packet on port 0 -> no state change, grant held; resumes cleanly when out_ready returns to 1.
- Head beat on port 2 with sop=0 in IDLE -> not granted, err_proto=1 next cycle and sticky; a second sop on the locked port also sets it.
- rst_n asserted while locked on port 1 -> locked=0 and grant=0 asynchronously; after release, port 0 has priority.
- NUM_PORTS=3 configuration: randomized traffic -> grant_idx never equals 3; no port waits more than 2 other packets.

Source files
------------

// File: rtl/pf_vf_mux_tx_arb_pkg.sv
// Shared types and helpers for the PF/VF MUX TX arbiter.
// Includes the arbiter state encoding and a one-hot to binary index encoder.
package pf_vf_mux_pkg;

  localparam int MAX_MUX_PORTS = 16;
  localparam int MAX_IDX_W     = $clog2(MAX_MUX_PORTS);

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } t_arb_state;

  // OR-reduction encoder: exact for one-hot inputs, and yields 0 for an all-zero input.
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_MUX_PORTS-1:0] onehot);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_MUX_PORTS; i++) begin
      if (onehot[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pf_vf_mux_tx_arb_if.sv
// Handshake bundle between the per-port TX FIFO heads and the TX arbiter.
// The master modport drives the beats; the slave modport is the arbiter side.
interface pf_vf_mux_tx_arb_if #(
  parameter int NUM_PORTS = 4
);
  localparam int PORT_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0] in_valid;
  logic [NUM_PORTS-1:0] in_sop;
  logic [NUM_PORTS-1:0] in_eop;
  logic                 out_ready;
  logic [NUM_PORTS-1:0] grant;
  logic [PORT_W-1:0]    grant_idx;
  logic                 out_valid;

  modport master (
    output in_valid, in_sop, in_eop, out_ready,
    input  grant, grant_idx, out_valid
  );

  modport slave (
    input  in_valid, in_sop, in_eop, out_ready,
    output grant, grant_idx, out_valid
  );

endinterface

// File: rtl/pf_vf_mux_tx_arb_rr_pick.sv
// Combinational round-robin picker: first request after last_idx, wrapping modulo NUM_PORTS.
// Implemented as a double-width rotate followed by a lowest-bit priority encode.
module pf_vf_mux_rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    last_idx,
  output logic [NUM_PORTS-1:0] pick,
  output logic [PORT_W-1:0]    idx,
  output logic                 any
);

  localparam int SUM_W = PORT_W + 2;

  logic [2*NUM_PORTS-1:0] dbl;
  logic [NUM_PORTS-1:0]   rot;
  logic [SUM_W-1:0]       rot_amt;
  logic [SUM_W-1:0]       offset;
  logic [SUM_W-1:0]       sum;
  logic                   found;

  always_comb begin
    rot_amt = SUM_W'(last_idx) + SUM_W'(1);
    if (rot_amt >= SUM_W'(NUM_PORTS)) rot_amt = '0;
    dbl    = {req, req};
    rot    = NUM_PORTS'(dbl >> rot_amt);
    offset = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!found && rot[k]) begin
        found  = 1'b1;
        offset = SUM_W'(k);
      end
    end
    // Fold back into range so non-power-of-2 port counts never produce an illegal index.
    sum = rot_amt + offset;
    if (sum >= SUM_W'(NUM_PORTS)) sum = sum - SUM_W'(NUM_PORTS);
    any  = found;
    idx  = found ? PORT_W'(sum) : '0;
    pick = found ? (NUM_PORTS'(1) << idx) : '0;
  end

endmodule

// File: rtl/pf_vf_mux_tx_arb.sv
// Packet-aware round-robin arbiter sharing the host-facing TX path among NUM_PORTS ports.
// A grant locks onto a port from its SOP beat until its EOP beat transfers.
module pf_vf_mux_tx_arb
  import pf_vf_mux_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  pf_vf_mux_tx_arb_if.slave   tx,
  output logic                locked,
  output logic                err_proto
);

  localparam int PORT_W = $clog2(NUM_PORTS);

  t_arb_state               state_r, state_n;
  logic [PORT_W-1:0]        lock_idx_r, lock_idx_n;
  logic [PORT_W-1:0]        last_idx_r, last_idx_n;
  logic                     err_r, err_n;
  logic [NUM_PORTS-1:0]     eligible;
  logic [NUM_PORTS-1:0]     pick_onehot;
  logic [PORT_W-1:0]        pick_idx;
  logic                     pick_any;
  logic [NUM_PORTS-1:0]     grant_int;
  logic [MAX_MUX_PORTS-1:0] grant_wide;

  assign eligible = tx.in_valid & tx.in_sop;

  pf_vf_mux_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_rr_pick (
    .req      (eligible),
    .last_idx (last_idx_r),
    .pick     (pick_onehot),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ARB_IDLE;
      lock_idx_r <= '0;
      last_idx_r <= PORT_W'(NUM_PORTS - 1);
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_n;
      lock_idx_r <= lock_idx_n;
      last_idx_r <= last_idx_n;
      err_r      <= err_n;
    end
  end

  always_comb begin
    state_n    = state_r;
    lock_idx_n = lock_idx_r;
    last_idx_n = last_idx_r;
    err_n      = err_r;
    grant_int  = '0;
    case (state_r)
      ARB_IDLE: begin
        grant_int = pick_onehot;
        if (tx.out_ready) begin
          if (|(tx.in_valid & ~tx.in_sop)) err_n = 1'b1;
          if (pick_any) begin
            last_idx_n = pick_idx;
            if (!tx.in_eop[pick_idx]) begin
              state_n    = ARB_LOCKED;
              lock_idx_n = pick_idx;
            end
          end
        end
      end
      ARB_LOCKED: begin
        grant_int = NUM_PORTS'(1) << lock_idx_r;
        if (tx.out_ready && tx.in_valid[lock_idx_r]) begin
          if (tx.in_sop[lock_idx_r]) err_n = 1'b1;
          if (tx.in_eop[lock_idx_r]) begin
            state_n    = ARB_IDLE;
            last_idx_n = lock_idx_r;
          end
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, even if FIFO heads still show valid.
  assign tx.grant     = rst_n ? grant_int : '0;
  assign tx.out_valid = |(tx.grant & tx.in_valid);
  assign grant_wide   = MAX_MUX_PORTS'(tx.grant);
  assign tx.grant_idx = PORT_W'(onehot_to_idx(grant_wide));
  assign locked       = (state_r == ARB_LOCKED);
  assign err_proto    = err_r;

endmodule

// File: tb/tb_pf_vf_mux_tx_arb.sv
// Directed bench for pf_vf_mux_tx_arb (4 ports) plus a 3-port traffic run.
module tb_pf_vf_mux_tx_arb;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic locked, err_proto;
  logic locked3, err_proto3;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   len3[3];
  int   beat3[3];
  int   waits3[3];

  pf_vf_mux_tx_arb_if #(.NUM_PORTS(4)) tx ();
  pf_vf_mux_tx_arb_if #(.NUM_PORTS(3)) tx3 ();

  pf_vf_mux_tx_arb #(.NUM_PORTS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx        (tx.slave),
    .locked    (locked),
    .err_proto (err_proto)
  );

  pf_vf_mux_tx_arb #(.NUM_PORTS(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx        (tx3.slave),
    .locked    (locked3),
    .err_proto (err_proto3)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] v, input logic [3:0] s, input logic [3:0] e, input logic rdy);
    @(negedge clk);
    tx.in_valid  = v;
    tx.in_sop    = s;
    tx.in_eop    = e;
    tx.out_ready = rdy;
    #1;
  endtask

  task automatic check_arb(input string tag, input logic [3:0] g, input int idx, input logic ov, input logic lk);
    check_output({tag, "_grant"},  32'(tx.grant),     32'(g));
    check_output({tag, "_idx"},    32'(tx.grant_idx), idx);
    check_output({tag, "_oval"},   32'(tx.out_valid), 32'(ov));
    check_output({tag, "_locked"}, 32'(locked),       32'(lk));
  endtask

  initial begin
    int p;
    tx.in_valid   = '0;
    tx.in_sop     = '0;
    tx.in_eop     = '0;
    tx.out_ready  = 1'b0;
    tx3.in_valid  = '0;
    tx3.in_sop    = '0;
    tx3.in_eop    = '0;
    tx3.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check_arb("reset", 4'b0000, 0, 1'b0, 1'b0);
    check_output("reset_err", 32'(err_proto), 0);
    rst_n = 1'b1;

    // Single-beat packets on every port rotate 0,1,2,3,0.
    for (int c = 0; c < 5; c++) begin
      apply_stimulus(4'b1111, 4'b1111, 4'b1111, 1'b1);
      check_arb("rr_single", 4'(1 << (c % 4)), c % 4, 1'b1, 1'b0);
    end

    // Three-beat packet on port 1 holds off port 2.
    apply_stimulus(4'b0110, 4'b0110, 4'b0100, 1'b1);
    check_arb("pkt1_b1", 4'b0010, 1, 1'b1, 1'b0);
    apply_stimulus(4'b0110, 4'b0100, 4'b0100, 1'b1);
    check_arb("pkt1_b2", 4'b0010, 1, 1'b1, 1'b1);
    apply_stimulus(4'b0110, 4'b0100, 4'b0110, 1'b1);
    check_arb("pkt1_b3", 4'b0010, 1, 1'b1, 1'b1);
    apply_stimulus(4'b0100, 4'b0100, 4'b0100, 1'b1);
    check_arb("pkt1_next", 4'b0100, 2, 1'b1, 1'b0);

    // Lock on port 3, valid gap of two cycles, then wrap to port 0.
    apply_stimulus(4'b1000, 4'b1000, 4'b0000, 1'b1);
    check_arb("lk3_sop", 4'b1000, 3, 1'b1, 1'b0);
    for (int c = 0; c < 2; c++) begin
      apply_stimulus(4'b0111, 4'b0111, 4'b0111, 1'b1);
      check_arb("lk3_gap", 4'b1000, 3, 1'b0, 1'b1);
    end
    apply_stimulus(4'b1111, 4'b0111, 4'b1111, 1'b1);
    check_arb("lk3_eop", 4'b1000, 3, 1'b1, 1'b1);
    apply_stimulus(4'b0111, 4'b0111, 4'b0111, 1'b1);
    check_arb("lk3_wrap", 4'b0001, 0, 1'b1, 1'b0);

    // Back-pressure mid-packet on port 0.
    apply_stimulus(4'b0001, 4'b0001, 4'b0000, 1'b1);
    check_arb("bp_sop", 4'b0001, 0, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      apply_stimulus(4'b0011, 4'b0010, 4'b0010, 1'b0);
      check_arb("bp_hold", 4'b0001, 0, 1'b1, 1'b1);
    end
    apply_stimulus(4'b0011, 4'b0010, 4'b0011, 1'b1);
    check_arb("bp_eop", 4'b0001, 0, 1'b1, 1'b1);
    apply_stimulus(4'b0010, 4'b0010, 4'b0010, 1'b1);
    check_arb("bp_next", 4'b0010, 1, 1'b1, 1'b0);
    check_output("bp_err", 32'(err_proto), 0);

    // Missing SOP at an idle head: never granted, error becomes sticky.
    apply_stimulus(4'b0100, 4'b0000, 4'b0100, 1'b1);
    check_arb("nosop", 4'b0000, 0, 1'b0, 1'b0);
    check_output("nosop_err0", 32'(err_proto), 0);
    apply_stimulus(4'b0000, 4'b0000, 4'b0000, 1'b1);
    check_output("nosop_err1", 32'(err_proto), 1);
    apply_stimulus(4'b0000, 4'b0000, 4'b0000, 1'b1);
    check_output("nosop_sticky", 32'(err_proto), 1);

    // Asynchronous reset while locked on port 1.
    apply_stimulus(4'b0010, 4'b0010, 4'b0000, 1'b1);
    check_arb("rst_sop", 4'b0010, 1, 1'b1, 1'b0);
    apply_stimulus(4'b0010, 4'b0000, 4'b0000, 1'b0);
    check_arb("rst_locked", 4'b0010, 1, 1'b1, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_arb("rst_async", 4'b0000, 0, 1'b0, 1'b0);
    check_output("rst_err", 32'(err_proto), 0);
    tx.in_valid = '0;
    tx.in_sop   = '0;
    tx.in_eop   = '0;
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(4'b1111, 4'b1111, 4'b1111, 1'b1);
    check_arb("rst_prio", 4'b0001, 0, 1'b1, 1'b0);

    // Repeated SOP on the locked port flags an error but keeps the lock.
    apply_stimulus(4'b0010, 4'b0010, 4'b0000, 1'b1);
    check_arb("dsop_b1", 4'b0010, 1, 1'b1, 1'b0);
    apply_stimulus(4'b0010, 4'b0010, 4'b0000, 1'b1);
    check_arb("dsop_b2", 4'b0010, 1, 1'b1, 1'b1);
    check_output("dsop_err0", 32'(err_proto), 0);
    apply_stimulus(4'b0010, 4'b0000, 4'b0010, 1'b1);
    check_arb("dsop_b3", 4'b0010, 1, 1'b1, 1'b1);
    check_output("dsop_err1", 32'(err_proto), 1);
    apply_stimulus(4'b0000, 4'b0000, 4'b0000, 1'b1);
    check_arb("dsop_done", 4'b0000, 0, 1'b0, 1'b0);

    // 3-port instance: every port always requesting with random packet lengths.
    for (int i = 0; i < 3; i++) begin
      len3[i]   = int'($urandom_range(1, 3));
      beat3[i]  = 0;
      waits3[i] = 0;
    end
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        tx3.in_valid[i] = 1'b1;
        tx3.in_sop[i]   = (beat3[i] == 0);
        tx3.in_eop[i]   = (beat3[i] == len3[i] - 1);
      end
      tx3.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      check_output("p3_idx_range", 32'(tx3.grant_idx < 2'd3), 1);
      check_output("p3_out_valid", 32'(tx3.out_valid), 1);
      p = int'(tx3.grant_idx);
      if (tx3.out_ready && tx3.out_valid && p < 3) begin
        if (tx3.in_sop[p]) waits3[p] = 0;
        if (tx3.in_eop[p]) begin
          for (int j = 0; j < 3; j++) begin
            if (j != p) begin
              waits3[j]++;
              check_output("p3_wait", 32'(waits3[j] <= 2), 1);
            end
          end
          beat3[p] = 0;
          len3[p]  = int'($urandom_range(1, 3));
        end else begin
          beat3[p]++;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
